subleq_sequencer: RTL
=====================

# subleq_sequencer

Multicycle control stage that drives the combinational SUBLEQ ALU. It fetches each three-word instruction (A, B, C) from a single-port synchronous memory and reads operands mem[A] and mem[B]. It presents them to the ALU as reg_1/reg_2, writes the ALU result back to mem[B], and updates the PC from the ALU branch flag. It sits between program/data memory and the ALU, and is the only sequential element in the core datapath.

## Interface

Parameters:
- WIDTH, 8: data word width; also the address width (memory depth 2^WIDTH words).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; honoured only in IDLE or HALT.
- start_pc  in  WIDTH  PC loaded when start is accepted.
- mem_addr  out  WIDTH  memory address.
- mem_rd  out  1  read strobe; data valid on mem_rdata the following cycle.
- mem_rdata  in  WIDTH  read data (1-cycle latency).
- mem_wr  out  1  write strobe.
- mem_wdata  out  WIDTH  write data.
- alu_a  out  WIDTH  operand mem[A], to ALU reg_1.
- alu_b  out  WIDTH  operand mem[B], to ALU reg_2.
- alu_result  in  WIDTH  ALU result (reg_2 − reg_1).
- alu_branch  in  1  ALU branch flag (result ≤ 0).
- pc  out  WIDTH  current PC.
- busy  out  1  high in any execute state.
- done  out  1  high in HALT.

## Operation

- States: IDLE, F_A, F_B, F_C, R_A, R_B, EX, WB, HALT.
- IDLE/HALT: if start, pc ← start_pc and go to F_A; otherwise hold.
- F_A: mem_addr=pc, mem_rd=1.
- F_B: mem_addr=pc+1, mem_rd=1; a_ptr ← mem_rdata.
- F_C: mem_addr=pc+2, mem_rd=1; b_ptr ← mem_rdata.
- R_A: mem_addr=a_ptr, mem_rd=1; c_ptr ← mem_rdata.
- R_B: mem_addr=b_ptr, mem_rd=1; opa ← mem_rdata.
- EX: opb ← mem_rdata; no memory access.
- WB: mem_addr=b_ptr, mem_wr=1, mem_wdata=alu_result.
  - If alu_branch, pc ← c_ptr; else pc ← pc+3.
  - Next state is HALT if alu_branch and c_ptr == all-ones; otherwise F_A.
- alu_a=opa and alu_b=opb at all times (registered). The ALU result is consumed only in WB.
- All PC and address arithmetic is modulo 2^WIDTH. pc+1, pc+2 and pc+3 wrap silently.
- The branch decision comes solely from alu_branch. The sequencer does not re-derive sign.
- Self-modifying code is permitted. A write in WB is visible to the next F_A fetch.
- mem_rd and mem_wr are never both high.
- In IDLE, HALT and EX: mem_rd=mem_wr=0, mem_addr=pc, mem_wdata=0.
- start in any non-IDLE/HALT state is ignored.

## Timing

- Reset (asynchronous) forces the following immediately, regardless of clock:
  - state=IDLE, pc=0, a_ptr=b_ptr=c_ptr=0, opa=opb=0.
  - mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, alu_a=alu_b=0, busy=0, done=0.
- Reset asserted during WB suppresses the write strobe immediately.
- start accepted at edge N: F_A is active in cycle N+1.
- Each instruction takes exactly 7 cycles (F_A through WB). The next instruction's F_A follows WB directly.
- busy=1 in F_A..WB. done=1 only in HALT, from the cycle after the halting WB.
- The pc output changes at the WB→next edge.
- Memory outputs are combinational from state and registers. There are no combinational paths from mem_rdata, alu_result or alu_branch to state, except mem_wdata=alu_result in WB.

## Configuration

- SUBLEQ_INSTR_COUNT_EN defined: adds output instr_count, 16 bits.
  - Reset to 0.
  - Cleared when start is accepted.
  - Incremented on each WB edge; saturates at 0xFFFF.
- SUBLEQ_INSTR_COUNT_EN undefined: the port and counter do not exist. Behaviour is otherwise identical.

## Test plan

- No-branch: mem[0..2]={10,11,3}, mem[10]=5, mem[11]=7, start_pc=0 -> after 7 cycles mem[11]=2, pc=3, exactly one mem_wr pulse at address 11.
- Branch: mem[10]=7, mem[11]=7, C=40 -> mem[11]=0, pc=40, next mem_rd address 40.
- Overflow edge with real ALU attached: mem[A]=0x80, mem[B]=0x00 -> mem[B]=0x80, alu_branch=0, pc advances by 3.
- Halt: branch taken with C=0xFF -> mem write performed, done=1 and busy=0 next cycle, pc=0xFF. start with start_pc=0 restarts at F_A.
- PC wrap: start_pc=0xFE, no branch -> fetches at 0xFE, 0xFF, 0x00; pc=0x01 after WB.
- Reset mid-instruction: assert reset during WB -> mem_wr falls without a clock edge, all outputs at reset values. With SUBLEQ_INSTR_COUNT_EN, instr_count=0, and equals 3 after three completed instructions.

Source files
------------

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: multicycle control stage for a SUBLEQ core.
// Fetches the three-word instruction (A, B, C), reads mem[A] and mem[B],
// presents them to the external combinational ALU, writes the ALU result
// back to mem[B] and steers the PC from the ALU branch flag.
//
// Handshake: start is a single-cycle request sampled on the rising edge and
// accepted only while the sequencer sits in IDLE or HALT; in any other state
// it is dropped. Memory reads return data on mem_rdata one cycle after mem_rd.
//
// Optional feature: define SUBLEQ_INSTR_COUNT_EN to add a 16-bit saturating
// instr_count output counting completed instructions since the last start.
module subleq_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] start_pc,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,
    output logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             done
`ifdef SUBLEQ_INSTR_COUNT_EN
    ,
    output logic [15:0]      instr_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F_A  = 4'd1,
        S_F_B  = 4'd2,
        S_F_C  = 4'd3,
        S_R_A  = 4'd4,
        S_R_B  = 4'd5,
        S_EX   = 4'd6,
        S_WB   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_ptr_q, a_ptr_d;
    logic [WIDTH-1:0] b_ptr_q, b_ptr_d;
    logic [WIDTH-1:0] c_ptr_q, c_ptr_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             start_accept;
    logic             halt_branch;

    // start only matters while parked; a halt needs a taken branch to all-ones
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign halt_branch  = alu_branch && (c_ptr_q == {WIDTH{1'b1}});

    // State register and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            a_ptr_q <= '0;
            b_ptr_q <= '0;
            c_ptr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_ptr_q <= a_ptr_d;
            b_ptr_q <= b_ptr_d;
            c_ptr_q <= c_ptr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Next-state and register capture; each read lands one state after its strobe
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        c_ptr_d = c_ptr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_accept) begin
                    pc_d    = start_pc;
                    state_d = S_F_A;
                end
            end
            S_F_A: state_d = S_F_B;
            S_F_B: begin
                a_ptr_d = mem_rdata;
                state_d = S_F_C;
            end
            S_F_C: begin
                b_ptr_d = mem_rdata;
                state_d = S_R_A;
            end
            S_R_A: begin
                c_ptr_d = mem_rdata;
                state_d = S_R_B;
            end
            S_R_B: begin
                opa_d   = mem_rdata;
                state_d = S_EX;
            end
            S_EX: begin
                opb_d   = mem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                // branch decision is taken from the ALU flag as-is
                pc_d    = alu_branch ? c_ptr_q : (pc_q + WIDTH'(3));
                state_d = halt_branch ? S_HALT : S_F_A;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port drive: purely from state and registers, result only in WB
    always_comb begin
        mem_addr  = pc_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_F_A: begin
                mem_addr = pc_q;
                mem_rd   = 1'b1;
            end
            S_F_B: begin
                mem_addr = pc_q + WIDTH'(1);
                mem_rd   = 1'b1;
            end
            S_F_C: begin
                mem_addr = pc_q + WIDTH'(2);
                mem_rd   = 1'b1;
            end
            S_R_A: begin
                mem_addr = a_ptr_q;
                mem_rd   = 1'b1;
            end
            S_R_B: begin
                mem_addr = b_ptr_q;
                mem_rd   = 1'b1;
            end
            S_WB: begin
                mem_addr  = b_ptr_q;
                mem_wr    = 1'b1;
                mem_wdata = alu_result;
            end
            default: begin
                mem_addr = pc_q;
            end
        endcase
    end

    assign alu_a = opa_q;
    assign alu_b = opb_q;
    assign pc    = pc_q;
    assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done  = (state_q == S_HALT);

`ifdef SUBLEQ_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    // Completed-instruction counter: cleared on accepted start, saturating
    always_comb begin
        count_d = count_q;
        if (start_accept) begin
            count_d = '0;
        end else if ((state_q == S_WB) && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`endif

endmodule
